// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder, one GROUP-bit lookahead group per stage (optional ovf via CLA_OVF_EN)
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTG = WIDTH / GROUP;
    // Operand delay registers exist between stages only; keep at least one entry so the array is legal.
    localparam int NFWD = (NSTG > 1) ? NSTG - 1 : 1;

    if (GROUP < 1 || GROUP > WIDTH || (WIDTH % GROUP) != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    logic             adv;
    logic             v_s [NSTG];
    logic             c_s [NSTG];
    logic [WIDTH-1:0] s_s [NSTG];
    logic [WIDTH-1:0] a_s [NFWD];
    logic [WIDTH-1:0] b_s [NFWD];
`ifdef CLA_OVF_EN
    logic             ovf_s;
`endif

    // Global stall: the whole pipe moves only when the output slot is free or being drained.
    assign adv       = !v_s[NSTG-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_s[NSTG-1];
    assign sum       = s_s[NSTG-1];
    assign cout      = c_s[NSTG-1];
`ifdef CLA_OVF_EN
    assign ovf       = ovf_s;
`endif

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic             v_in;
        logic             c_in;
        logic [GROUP-1:0] ag;
        logic [GROUP-1:0] bg;
        logic [WIDTH-1:0] s_in;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   cy;
        logic [WIDTH-1:0] s_d;
        logic             c_d;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_first
            assign v_in = in_valid;
            assign c_in = cin;
            assign ag   = a[0 +: GROUP];
            assign bg   = b[0 +: GROUP];
            assign s_in = '0;
        end else begin : g_mid
            assign v_in = v_s[k-1];
            assign c_in = c_s[k-1];
            assign ag   = a_s[k-1][k*GROUP +: GROUP];
            assign bg   = b_s[k-1][k*GROUP +: GROUP];
            assign s_in = s_s[k-1];
        end

        // Lookahead over this group: each carry is the fully expanded sum-of-products of g/p and the group carry-in.
        always_comb begin : p_cla
            logic term;
            logic prod;
            term = 1'b0;
            prod = 1'b1;
            g    = ag & bg;
            p    = ag ^ bg;
            cy   = '0;
            cy[0] = c_in;
            for (int i = 0; i < GROUP; i++) begin
                term = 1'b0;
                prod = 1'b1;
                for (int j = i; j >= 0; j--) begin
                    term = term | (prod & g[j]);
                    prod = prod & p[j];
                end
                cy[i+1] = term | (prod & c_in);
            end
            s_d = s_in;
            s_d[k*GROUP +: GROUP] = p ^ cy[GROUP-1:0];
            c_d = cy[GROUP];
        end

        // Stage register: valid, group carry-out and the sum slices finished so far.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        assign v_s[k] = v_q;
        assign c_s[k] = c_q;
        assign s_s[k] = s_q;

        if (k < NSTG - 1) begin : g_fwd
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] b_src;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            if (k == 0) begin : g_src_in
                assign a_src = a;
                assign b_src = b;
            end else begin : g_src_pipe
                assign a_src = a_s[k-1];
                assign b_src = b_s[k-1];
            end

            // Operand delay registers carry the not-yet-consumed groups alongside the beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src;
                    b_q <= b_src;
                end
            end

            assign a_s[k] = a_q;
            assign b_s[k] = b_q;
        end

`ifdef CLA_OVF_EN
        if (k == NSTG - 1) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            // The top group holds the sign bits, so overflow is decided in the last stage.
            assign ovf_d = (ag[GROUP-1] == bg[GROUP-1]) && (s_d[WIDTH-1] != ag[GROUP-1]);

            // Overflow flag registered and held exactly like sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign ovf_s = ovf_q;
        end
`endif
    end

endmodule
